// File: rtl/pool_pkg.sv
// Shared definitions for the fp16 max-pool sequencer.
//   FP16_W        width of an IEEE half-precision operand
//   FP16_NEG_INF  fp16 encoding of negative infinity
//   CMP_GT_BIT    bit of the comparator result that reports a > b
//   state_t       sequencer FSM state encoding
package pool_pkg;

    localparam int          FP16_W       = 16;
    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam int          CMP_GT_BIT   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/fp16_maxpool_sequencer.sv
// Streaming fp16 max-pool controller. Reduces every WINDOW accepted input
// samples to their maximum using an external, zero-latency floating-point
// comparator, and emits one result per window. m_tlast flags the last result
// of each row of ROW_WINDOWS results.
//
// Ports:
//   clock          rising-edge clock
//   rst_n          asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata   fp16 input stream
//   m_tvalid/m_tready/m_tdata/m_tlast   pooled result stream
//   cmp_a_tvalid/cmp_a_tdata    comparator operand a (candidate sample)
//   cmp_b_tvalid/cmp_b_tdata    comparator operand b (running maximum)
//   cmp_re_tvalid/cmp_re_tdata  comparator result, bit CMP_GT_BIT = a > b
module fp16_maxpool_sequencer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int WINDOW      = 4,
    parameter int ROW_WINDOWS = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  cmp_a_tvalid,
    output logic [DATA_WIDTH-1:0] cmp_a_tdata,
    output logic                  cmp_b_tvalid,
    output logic [DATA_WIDTH-1:0] cmp_b_tdata,
    input  logic                  cmp_re_tvalid,
    input  logic [7:0]            cmp_re_tdata
);

    localparam int ELEM_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int ROW_W  = (ROW_WINDOWS > 1) ? $clog2(ROW_WINDOWS) : 1;

    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(WINDOW - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_WINDOWS - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [ELEM_W-1:0]       elem_cnt;
    logic [ROW_W-1:0]        win_cnt;
    logic [DATA_WIDTH-1:0]   max_q;
    logic                    rdy_q;
    logic                    cmp_err_q;

    logic                    s_accept;
    logic                    cmp_gt;
    logic                    cmp_unused;

    assign s_accept   = s_tvalid & s_tready;
    // A result only counts when the comparator marks it valid.
    assign cmp_gt     = cmp_re_tvalid & cmp_re_tdata[CMP_GT_BIT];
    assign cmp_unused = ^cmp_re_tdata[7:1];

    // Registered state: FSM, counters and running maximum.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            max_q     <= '0;
            rdy_q     <= 1'b0;
            cmp_err_q <= 1'b0;
        end else begin
            // Input side stays closed for the first cycle out of reset.
            rdy_q   <= 1'b1;
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (s_accept) begin
                        max_q    <= s_tdata;
                        elem_cnt <= ELEM_W'(1);
                    end
                end
                ACCUM: begin
                    if (s_accept) begin
                        if (cmp_gt) begin
                            max_q <= s_tdata;
                        end
                        // Missing comparator result: keep max_q, flag it.
                        if (!cmp_re_tvalid) begin
                            cmp_err_q <= 1'b1;
                        end
                        elem_cnt <= (elem_cnt == ELEM_LAST) ? '0 : elem_cnt + ELEM_W'(1);
                    end
                end
                OUTPUT: begin
                    if (m_tready) begin
                        win_cnt <= (win_cnt == ROW_LAST) ? '0 : win_cnt + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and stream / comparator outputs.
    always_comb begin
        state_d      = state_q;
        s_tready     = 1'b0;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tlast      = 1'b0;
        cmp_a_tvalid = 1'b0;
        cmp_b_tvalid = 1'b0;
        cmp_a_tdata  = s_tdata;
        cmp_b_tdata  = max_q;
        case (state_q)
            IDLE: begin
                s_tready = rdy_q;
                if (s_tvalid && rdy_q) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                s_tready     = rdy_q;
                cmp_a_tvalid = s_tvalid;
                cmp_b_tvalid = s_tvalid;
                if (s_accept && (elem_cnt == ELEM_LAST)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                m_tvalid = 1'b1;
                m_tdata  = max_q;
                m_tlast  = (win_cnt == ROW_LAST);
                if (m_tready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp16_maxpool_sequencer.sv
module tb_fp16_maxpool_sequencer;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        cmp_a_tvalid;
    logic [15:0] cmp_a_tdata;
    logic        cmp_b_tvalid;
    logic [15:0] cmp_b_tdata;
    logic        cmp_re_tvalid;
    logic [7:0]  cmp_re_tdata;
    logic        cmp_drop = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int out_idx = 0;

    logic [15:0] win [4];
    logic [16:0] got [$];
    logic [16:0] expq [$];
    logic [16:0] drained [$];
    logic [16:0] gapfree [$];

    always #5 clock = ~clock;

    fp16_maxpool_sequencer #(
        .DATA_WIDTH (16),
        .WINDOW     (4),
        .ROW_WINDOWS(2)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .cmp_a_tvalid (cmp_a_tvalid),
        .cmp_a_tdata  (cmp_a_tdata),
        .cmp_b_tvalid (cmp_b_tvalid),
        .cmp_b_tdata  (cmp_b_tdata),
        .cmp_re_tvalid(cmp_re_tvalid),
        .cmp_re_tdata (cmp_re_tdata)
    );

    // Behavioural fp16 arithmetic used both for the comparator and the reference.
    function automatic bit is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 0);
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        real v;
        e = int'(h[14:10]);
        m = real'(h[9:0]);
        if (e == 0)       v = m * (2.0 ** (-24));
        else if (e == 31) v = 1.0e9;
        else              v = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -v : v;
    endfunction

    function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
        if (is_nan(a) || is_nan(b)) return 1'b0;
        return h2r(a) > h2r(b);
    endfunction

    // Zero-latency comparator model.
    assign cmp_re_tvalid = cmp_a_tvalid & cmp_b_tvalid & ~cmp_drop;
    assign cmp_re_tdata  = {7'b0, fp_gt(cmp_a_tdata, cmp_b_tdata)};

    always @(posedge clock) begin
        if (rst_n && m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: first sample seeds the max, later samples replace it only if
    // strictly greater; a beat with no comparator result is ignored.
    task automatic expect_window(input int drop_idx);
        logic [15:0] cur;
        cur = win[0];
        for (int i = 1; i < 4; i++) begin
            if (i != drop_idx && fp_gt(win[i], cur)) cur = win[i];
        end
        expq.push_back({(out_idx % 2 == 1), cur});
        out_idx++;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        while (!s_tready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
        @(negedge clock);
        s_tvalid = 1'b0;
    endtask

    task automatic run_window(input int maxgap, input int drop_idx);
        expect_window(drop_idx);
        for (int i = 0; i < 4; i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clock);
            cmp_drop = (i == drop_idx);
            send(win[i]);
            cmp_drop = 1'b0;
        end
    endtask

    task automatic rand_window();
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) win[i] = 16'h7E00;
            else win[i] = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic wait_results(input string tag);
        int n;
        n = 0;
        while (got.size() < expq.size() && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
        while (got.size() > 0 && expq.size() > 0) begin
            logic [16:0] g;
            logic [16:0] e;
            g = got.pop_front();
            e = expq.pop_front();
            drained.push_back(g);
            chk({tag, "_data"}, 32'(g[15:0]), 32'(e[15:0]));
            chk({tag, "_last"}, 32'(g[16]), 32'(e[16]));
        end
        got.delete();
        expq.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_cmp_valid", 32'({cmp_a_tvalid, cmp_b_tvalid}), 0);
        chk("rst_elem_cnt", 32'(dut.elem_cnt), 0);
        chk("rst_win_cnt", 32'(dut.win_cnt), 0);
        rst_n = 1'b1;
        chk("rst_release_s_tready", 32'(s_tready), 0);
        @(negedge clock);
        chk("post_rst_s_tready", 32'(s_tready), 1);

        // T1: mixed signs, latency
        win = '{16'h0000, 16'hCA40, 16'h4A40, 16'h4910};
        expect_window(-1);
        send(win[0]); send(win[1]); send(win[2]);
        chk("t1_no_early_valid", 32'(m_tvalid), 0);
        send(win[3]);
        chk("t1_m_tvalid", 32'(m_tvalid), 1);
        chk("t1_m_tdata", 32'(m_tdata), 32'h4A40);
        chk("t1_m_tlast", 32'(m_tlast), 0);
        chk("t1_s_tready_out", 32'(s_tready), 0);
        wait_results("t1");

        // T2: all negative, second window of the row
        win = '{16'hCA40, 16'hC900, 16'hCC00, 16'hCA41};
        expect_window(-1);
        for (int i = 0; i < 4; i++) send(win[i]);
        chk("t2_m_tdata", 32'(m_tdata), 32'hC900);
        chk("t2_m_tlast", 32'(m_tlast), 1);
        wait_results("t2");

        // T3: backpressure
        m_tready = 1'b0;
        win = '{16'h3C00, 16'h4500, 16'h4400, 16'hBC00};
        run_window(0, -1);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(m_tvalid), 1);
            chk("t3_hold_data", 32'(m_tdata), 32'h4500);
            chk("t3_hold_last", 32'(m_tlast), 0);
            chk("t3_hold_s_tready", 32'(s_tready), 0);
            chk("t3_hold_no_output", 32'(got.size()), 0);
            @(negedge clock);
        end
        m_tready = 1'b1;
        @(negedge clock);
        chk("t3_one_result", 32'(got.size()), 1);
        chk("t3_valid_drop", 32'(m_tvalid), 0);
        wait_results("t3");

        // T4: signed-zero tie and NaN head
        win = '{16'h0000, 16'h8000, 16'h0000, 16'h8000};
        run_window(0, -1);
        win = '{16'h7E00, 16'h3C00, 16'h4000, 16'h3800};
        run_window(0, -1);
        chk("t4_tie_expect", 32'(expq[0][15:0]), 32'h0000);
        chk("t4_nan_expect", 32'(expq[1][15:0]), 32'h7E00);
        wait_results("t4");

        // Filler so the T5 batches start on a row boundary.
        rand_window();
        run_window(0, -1);
        wait_results("fill");

        // T5: same 8 windows gap-free, then with random input gaps
        begin
            logic [15:0] saved [8][4];
            for (int w = 0; w < 8; w++) begin
                rand_window();
                for (int i = 0; i < 4; i++) saved[w][i] = win[i];
            end
            drained.delete();
            for (int w = 0; w < 8; w++) begin
                for (int i = 0; i < 4; i++) win[i] = saved[w][i];
                run_window(0, -1);
            end
            wait_results("t5_nogap");
            gapfree = drained;
            drained.delete();
            for (int w = 0; w < 8; w++) begin
                for (int i = 0; i < 4; i++) win[i] = saved[w][i];
                run_window(3, -1);
            end
            wait_results("t5_gap");
            chk("t5_batch_size", 32'(drained.size()), 32'(gapfree.size()));
            for (int k = 0; k < drained.size() && k < gapfree.size(); k++) begin
                chk("t5_same_as_nogap", 32'(drained[k]), 32'(gapfree[k]));
                chk("t5_last_pattern", 32'(drained[k][16]), 32'(k % 2));
            end
        end

        // Missing comparator result holds max and sets the sticky flag.
        chk("err_clear", 32'(dut.cmp_err_q), 0);
        win = '{16'h3C00, 16'h4000, 16'h3E00, 16'h3800};
        run_window(0, 1);
        chk("err_expect", 32'(expq[0][15:0]), 32'h3E00);
        wait_results("err");
        chk("err_sticky", 32'(dut.cmp_err_q), 1);

        // T6: asynchronous reset after two accepts
        send(16'h4000);
        send(16'h4200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_m_tvalid", 32'(m_tvalid), 0);
        chk("t6_s_tready", 32'(s_tready), 0);
        chk("t6_m_tdata", 32'(m_tdata), 0);
        chk("t6_cmp_valid", 32'({cmp_a_tvalid, cmp_b_tvalid}), 0);
        chk("t6_elem_cnt", 32'(dut.elem_cnt), 0);
        chk("t6_win_cnt", 32'(dut.win_cnt), 0);
        chk("t6_err_cleared", 32'(dut.cmp_err_q), 0);
        @(negedge clock);
        rst_n = 1'b1;
        got.delete();
        out_idx = 0;
        @(negedge clock);
        win = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        run_window(0, -1);
        chk("t6_m_tdata", 32'(m_tdata), 32'h4400);
        chk("t6_m_tlast", 32'(m_tlast), 0);
        wait_results("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
